multi_clk_div: RTL and testbench

- Parametrised, multi-channel successor to the fixed 1 Hz divider.
- Produces CH independent divided clocks from the 100 MHz system clock, each with a square-wave output and a one-cycle tick strobe.
- Each channel has a divide ratio that is runtime-loadable, plus its own enable; a common sync re-phases all channels.
- Feeds LED/colour sequencing, display refresh and timing logic that need several slow rates at once.

---
 rtl/multi_clk_div.sv | 130 +++++++++++++
 tb/tb_multi_clk_div.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_clk_div.sv
// -----------------------------------------------------------------------------
// multi_clk_div
//
// Multi-channel programmable clock divider. Each of CH channels divides the
// system clock by its own runtime-loadable ratio and produces a registered
// square wave (high for floor(d/2) cycles, low for ceil(d/2) cycles) plus a
// one-cycle tick strobe at the counter wrap, once per output period.
//
// Ports:
//   clk       in   1      system clock, all logic on posedge
//   rst       in   1      asynchronous, active-high reset
//   en        in   CH     per-channel enable; low holds count and clk_out,
//                         forces tick low
//   sync      in   1      one-cycle pulse; restarts every channel at count 0
//   load      in   1      one-cycle pulse; writes load_div into load_ch
//   load_ch   in   LCH_W  target channel for load (values >= CH ignored)
//   load_div  in   CNT_W  new divide ratio (0 and 1 are stored as 2)
//   clk_out   out  CH     registered divided square waves
//   tick      out  CH     registered one-cycle strobes at each period end
//
// Control pulse semantics: sync and load are plain single-cycle qualifiers
// sampled on the rising clock edge; there is no back-pressure, a pulse is
// always accepted on the edge where it is high. Both may be high together:
// the loaded channel takes its new ratio and every counter restarts.
// -----------------------------------------------------------------------------
module multi_clk_div #(
    parameter int unsigned CLK_HZ  = 100000000,
    parameter int unsigned DEF_HZ  = 1,
    parameter int unsigned DEF_DIV = CLK_HZ / DEF_HZ,
    parameter int unsigned CH      = 4,
    parameter int unsigned CNT_W   = 27,
    localparam int unsigned LCH_W  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CH-1:0]    en,
    input  logic             sync,
    input  logic             load,
    input  logic [LCH_W-1:0] load_ch,
    input  logic [CNT_W-1:0] load_div,
    output logic [CH-1:0]    clk_out,
    output logic [CH-1:0]    tick
);

    // Ratios below 2 cannot produce a square wave; they are stored as 2 so
    // the effective ratio is always simply the stored value.
    function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] v);
        return (v < CNT_W'(2)) ? CNT_W'(2) : v;
    endfunction

    localparam logic [CNT_W-1:0] DEF_DIV_C =
        (DEF_DIV < 2) ? CNT_W'(2) : CNT_W'(DEF_DIV);

    // Per-channel state
    logic [CNT_W-1:0] div_q [CH];
    logic [CNT_W-1:0] div_d [CH];
    logic [CNT_W-1:0] cnt_q [CH];
    logic [CNT_W-1:0] cnt_d [CH];
    logic [CH-1:0]    clk_out_q;
    logic [CH-1:0]    clk_out_d;
    logic [CH-1:0]    tick_q;
    logic [CH-1:0]    tick_d;

    // Decodes of the pre-edge count; outputs are registered from these, so
    // they lag the counter by one cycle.
    logic [CNT_W-1:0] half   [CH];
    logic [CH-1:0]    wrap;
    logic [CH-1:0]    load_hit;

    always_comb begin
        for (int i = 0; i < CH; i++) begin
            half[i]     = div_q[i] >> 1;
            wrap[i]     = (cnt_q[i] == (div_q[i] - CNT_W'(1)));
            // Channel indices beyond CH-1 never match, so an out-of-range
            // load_ch falls through without touching any channel.
            load_hit[i] = load && (load_ch == LCH_W'(i));
        end
    end

    always_comb begin
        for (int i = 0; i < CH; i++) begin
            div_d[i]     = div_q[i];
            cnt_d[i]     = cnt_q[i];
            clk_out_d[i] = clk_out_q[i];
            tick_d[i]    = 1'b0;

            if (sync) begin
                // Re-phase regardless of enable: the next period of every
                // channel starts on the following edge, output high.
                cnt_d[i]     = '0;
                clk_out_d[i] = 1'b1;
            end else if (en[i]) begin
                cnt_d[i]     = wrap[i] ? '0 : (cnt_q[i] + CNT_W'(1));
                clk_out_d[i] = (cnt_q[i] < half[i]);
                tick_d[i]    = wrap[i];
            end

            // A load restarts its channel too, which also makes shrinking the
            // ratio below the current count safe.
            if (load_hit[i]) begin
                div_d[i]     = clamp_div(load_div);
                cnt_d[i]     = '0;
                clk_out_d[i] = 1'b1;
                tick_d[i]    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                div_q[i] <= DEF_DIV_C;
                cnt_q[i] <= '0;
            end
            clk_out_q <= '0;
            tick_q    <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                div_q[i] <= div_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_multi_clk_div.sv
// -----------------------------------------------------------------------------
// Bench for multi_clk_div. Main instance: CH=4, DEF_DIV=10. A second small
// instance with CH=3 exercises a load_ch value that is representable but out
// of range.
// -----------------------------------------------------------------------------
module tb_multi_clk_div;

    localparam int CH    = 4;
    localparam int CNT_W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [CH-1:0]    en;
    logic             sync;
    logic             load;
    logic [1:0]       load_ch;
    logic [CNT_W-1:0] load_div;
    logic [CH-1:0]    clk_out;
    logic [CH-1:0]    tick;

    logic       rst3;
    logic [2:0] en3;
    logic       sync3;
    logic       load3;
    logic [1:0] load_ch3;
    logic [3:0] load_div3;
    logic [2:0] clk_out3;
    logic [2:0] tick3;

    multi_clk_div #(
        .DEF_DIV (10),
        .CH      (CH),
        .CNT_W   (CNT_W)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sync     (sync),
        .load     (load),
        .load_ch  (load_ch),
        .load_div (load_div),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    multi_clk_div #(
        .DEF_DIV (4),
        .CH      (3),
        .CNT_W   (4)
    ) u_dut3 (
        .clk      (clk),
        .rst      (rst3),
        .en       (en3),
        .sync     (sync3),
        .load     (load3),
        .load_ch  (load_ch3),
        .load_div (load_div3),
        .clk_out  (clk_out3),
        .tick     (tick3)
    );

    // ---------------- scoreboard / counters ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_div [CH];
    int         m_cnt [CH];
    logic [CH-1:0] m_clk;
    logic [CH-1:0] m_tick;

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_div[i] = 10;
            m_cnt[i] = 0;
        end
        m_clk  = '0;
        m_tick = '0;
    endtask

    task automatic model_step(input logic [CH-1:0] e, input logic s, input logic l,
                              input logic [1:0] lc, input logic [CNT_W-1:0] ld);
        for (int i = 0; i < CH; i++) begin
            if (l && int'(lc) == i) begin
                m_div[i]  = (int'(ld) < 2) ? 2 : int'(ld);
                m_cnt[i]  = 0;
                m_clk[i]  = 1'b1;
                m_tick[i] = 1'b0;
            end else if (s) begin
                m_cnt[i]  = 0;
                m_clk[i]  = 1'b1;
                m_tick[i] = 1'b0;
            end else if (e[i]) begin
                m_clk[i]  = (m_cnt[i] < m_div[i] / 2);
                m_tick[i] = (m_cnt[i] == m_div[i] - 1);
                m_cnt[i]  = (m_cnt[i] + 1) % m_div[i];
            end else begin
                m_tick[i] = 1'b0;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clock: drive inputs, predict, let the edge happen, compare 1ns later.
    task automatic cycle(input logic [CH-1:0] e, input logic s, input logic l,
                         input logic [1:0] lc, input logic [CNT_W-1:0] ld);
        logic [7:0] exp_v;
        en       = e;
        sync     = s;
        load     = l;
        load_ch  = lc;
        load_div = ld;
        model_step(e, s, l, lc, ld);
        exp_q.push_back({m_clk, m_tick});
        @(posedge clk);
        #1;
        exp_v = exp_q.pop_front();
        check("scoreboard", 32'({clk_out, tick}), 32'(exp_v));
        sync = 1'b0;
        load = 1'b0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle(4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
    endtask

    int hi_n [CH];
    int tk_n [CH];
    task automatic run_count(input int n);
        for (int i = 0; i < CH; i++) begin
            hi_n[i] = 0;
            tk_n[i] = 0;
        end
        for (int k = 0; k < n; k++) begin
            cycle(4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
            for (int i = 0; i < CH; i++) begin
                hi_n[i] += int'(clk_out[i]);
                tk_n[i] += int'(tick[i]);
            end
        end
    endtask

    // Cycle index (1-based, counted after the current edge) of each
    // channel's first tick, -1 if none within the limit.
    int ft [CH];
    task automatic first_ticks(input int limit);
        for (int i = 0; i < CH; i++) ft[i] = -1;
        for (int k = 1; k <= limit; k++) begin
            cycle(4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
            for (int i = 0; i < CH; i++)
                if (ft[i] < 0 && tick[i]) ft[i] = k;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [CH-1:0] en;
        logic          exp_clk0;
        logic          exp_tick0;
    } vec_t;

    vec_t       tbl [20];
    logic [19:0] clk_pat;
    logic [19:0] tick_pat;

    initial begin
        // Cycle 1 after reset release is the MSB. d=10: 5 high, 5 low,
        // tick on the 10th cycle of each period.
        clk_pat  = 20'b11111000001111100000;
        tick_pat = 20'b00000000010000000001;
        for (int k = 0; k < 20; k++) begin
            tbl[k].en        = 4'hF;
            tbl[k].exp_clk0  = clk_pat[19-k];
            tbl[k].exp_tick0 = tick_pat[19-k];
        end

        rst = 1'b1;  en = 4'hF; sync = 1'b0; load = 1'b0; load_ch = 2'd0; load_div = '0;
        rst3 = 1'b1; en3 = 3'b111; sync3 = 1'b0; load3 = 1'b0; load_ch3 = 2'd0; load_div3 = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_clk_out",  32'(clk_out),  32'(0));
        check("reset_tick",     32'(tick),     32'(0));
        check("reset_clk_out3", 32'(clk_out3), 32'(0));

        // ---- out-of-range load_ch on the CH=3 instance (d=4 throughout) ----
        rst3 = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            int c;
            load3     = (k == 3);
            load_ch3  = 2'd3;
            load_div3 = 4'd2;
            @(posedge clk);
            #1;
            load3 = 1'b0;
            c = (k - 1) % 4;
            check("oor_clk", 32'(clk_out3), (c < 2)  ? 32'h7 : 32'h0);
            check("oor_tick", 32'(tick3),   (c == 3) ? 32'h7 : 32'h0);
        end
        check("held_reset_clk_out", 32'(clk_out), 32'(0));

        // ---- test 1: reset release, default ratio 10 ----
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 20; k++) begin
            cycle(tbl[k].en, 1'b0, 1'b0, 2'd0, 8'd0);
            check("t1_clk0",  32'(clk_out[0]), 32'(tbl[k].exp_clk0));
            check("t1_tick0", 32'(tick[0]),    32'(tbl[k].exp_tick0));
        end

        // ---- test 2: ratios 7, 1, 0 ----
        cycle(4'hF, 1'b0, 1'b1, 2'd1, 8'd7);
        cycle(4'hF, 1'b0, 1'b1, 2'd2, 8'd1);
        cycle(4'hF, 1'b0, 1'b1, 2'd3, 8'd0);
        run_count(14);
        check("t2_ch1_high", 32'(hi_n[1]), 32'(6));
        check("t2_ch1_tick", 32'(tk_n[1]), 32'(2));
        check("t2_ch2_high", 32'(hi_n[2]), 32'(7));
        check("t2_ch2_tick", 32'(tk_n[2]), 32'(7));
        check("t2_ch3_high", 32'(hi_n[3]), 32'(7));
        check("t2_ch3_tick", 32'(tk_n[3]), 32'(7));

        // ---- test 3: enable gap on ch0 with d=4 ----
        cycle(4'hF, 1'b0, 1'b1, 2'd0, 8'd4);
        run(3);
        check("t3_pre_clk0", 32'(clk_out[0]), 32'(0));
        for (int k = 0; k < 3; k++) begin
            cycle(4'hE, 1'b0, 1'b0, 2'd0, 8'd0);
            check("t3_hold_clk0", 32'(clk_out[0]), 32'(0));
            check("t3_hold_tick0", 32'(tick[0]),   32'(0));
        end
        cycle(4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
        check("t3_resume_clk0",  32'(clk_out[0]), 32'(0));
        check("t3_resume_tick0", 32'(tick[0]),    32'(1));
        cycle(4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
        check("t3_next_clk0",  32'(clk_out[0]), 32'(1));
        check("t3_next_tick0", 32'(tick[0]),    32'(0));

        // ---- test 4: ratios 3, 5, 8, 10 then sync ----
        cycle(4'hF, 1'b0, 1'b1, 2'd0, 8'd3);
        cycle(4'hF, 1'b0, 1'b1, 2'd1, 8'd5);
        cycle(4'hF, 1'b0, 1'b1, 2'd2, 8'd8);
        cycle(4'hF, 1'b0, 1'b1, 2'd3, 8'd10);
        run(7);
        cycle(4'hF, 1'b1, 1'b0, 2'd0, 8'd0);
        check("t4_sync_clk", 32'(clk_out), 32'hF);
        check("t4_sync_tick", 32'(tick),   32'h0);
        first_ticks(12);
        check("t4_ft0", 32'(ft[0]), 32'(3));
        check("t4_ft1", 32'(ft[1]), 32'(5));
        check("t4_ft2", 32'(ft[2]), 32'(8));
        check("t4_ft3", 32'(ft[3]), 32'(10));

        // ---- test 5: simultaneous load(ch0, 6) and sync ----
        run(3);
        cycle(4'hF, 1'b1, 1'b1, 2'd0, 8'd6);
        check("t5_sync_clk", 32'(clk_out), 32'hF);
        check("t5_sync_tick", 32'(tick),   32'h0);
        first_ticks(12);
        check("t5_ft0", 32'(ft[0]), 32'(6));
        check("t5_ft1", 32'(ft[1]), 32'(5));
        check("t5_ft2", 32'(ft[2]), 32'(8));
        check("t5_ft3", 32'(ft[3]), 32'(10));

        // ---- test 6: asynchronous reset mid-cycle ----
        run(2);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_clk", 32'(clk_out), 32'h0);
        check("t6_async_tick", 32'(tick),   32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cycle(4'hF, 1'b0, 1'b0, 2'd0, 8'd0);
            check("t6_clk",  32'(clk_out), clk_pat[19-k]  ? 32'hF : 32'h0);
            check("t6_tick", 32'(tick),    tick_pat[19-k] ? 32'hF : 32'h0);
        end

        check("queue_empty", 32'(exp_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
